// File: rtl/trace_capture.sv
// trace_capture: arm/trigger trace ring for the datapath PC and NUM_CH register-read values, drained oldest-first.
// Define TRACE_CAPTURE_TIMESTAMP_EN to stamp each entry with a 32-bit cycle count, read back on rd_ts.
module trace_capture #(
    parameter int PC_WIDTH   = 64,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = 16,
    parameter int POST_TRIG  = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         cap_en,
    input  logic [PC_WIDTH-1:0]          pc_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         mode,
    input  logic                         arm,
    input  logic                         trig,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [PC_WIDTH-1:0]          rd_pc,
    output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    output logic [31:0]                  rd_ts,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [1:0]                   state,
    output logic                         overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int DW    = NUM_CH*DATA_WIDTH;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    localparam int ENT_W = 32 + PC_WIDTH + DW;
`else
    localparam int ENT_W = PC_WIDTH + DW;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   post_cnt_r;
    logic [CNT_W-1:0]   count_r;
    logic               overflow_r;
    logic               mode_r;
    logic               wr_en_s;
    logic               pop_s;
    logic               full_s;
    logic [ENT_W-1:0]   entry_s;
    logic [ENT_W-1:0]   rd_entry_s;
    logic [ENT_W-1:0]   mem [DEPTH];

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    logic [31:0]        ts_r;

    // Free-running cycle stamp, wraps naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_r <= 32'd0;
        end else begin
            ts_r <= ts_r + 32'd1;
        end
    end

    assign entry_s = {ts_r, pc_in, data_in};
    assign rd_ts   = rd_valid ? rd_entry_s[DW+PC_WIDTH +: 32] : 32'd0;
`else
    assign entry_s = {pc_in, data_in};
`endif

    assign full_s = (count_r == CNT_W'(DEPTH));

    // Write/pop qualifiers; arm pre-empts every other action in its cycle.
    always_comb begin
        wr_en_s = 1'b0;
        pop_s   = 1'b0;
        if (arm) begin
            wr_en_s = 1'b0;
            pop_s   = 1'b0;
        end else if (state_r == ST_ARMED || state_r == ST_POST) begin
            wr_en_s = cap_en;
        end else if (state_r == ST_DONE) begin
            pop_s = rd_ready && (count_r != CNT_W'(0));
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next-state logic for the arm/trigger/drain sequence.
    always_comb begin
        state_nxt_s = state_r;
        if (arm) begin
            state_nxt_s = ST_ARMED;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_IDLE;
                ST_ARMED: begin
                    if (!mode_r) begin
                        if (trig || (wr_en_s && count_r == CNT_W'(DEPTH-1))) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_ARMED;
                        end
                    end else if (trig) begin
                        state_nxt_s = (POST_TRIG == 0) ? ST_DONE : ST_POST;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_POST: begin
                    if (wr_en_s && post_cnt_r == PTR_W'(1)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_POST;
                    end
                end
                ST_DONE:  state_nxt_s = ST_DONE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pointers, occupancy and sticky overflow; a write into a full ring drops the oldest entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            mode_r     <= 1'b0;
        end else if (arm) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            mode_r     <= mode;
        end else if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (full_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
                overflow_r <= 1'b1;
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r  <= count_r - CNT_W'(1);
        end
    end

    // Post-trigger sample budget, loaded when a ring-mode trigger lands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            post_cnt_r <= '0;
        end else if (arm) begin
            post_cnt_r <= '0;
        end else if (state_r == ST_ARMED && mode_r && trig) begin
            post_cnt_r <= PTR_W'(POST_TRIG);
        end else if (state_r == ST_POST && wr_en_s) begin
            post_cnt_r <= post_cnt_r - PTR_W'(1);
        end
    end

    // Storage array carries no reset; outputs are masked until an entry is valid.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem[wr_ptr_r] <= entry_s;
        end
    end

    assign rd_entry_s = mem[rd_ptr_r];
    assign rd_valid   = (state_r == ST_DONE) && (count_r != CNT_W'(0));
    assign rd_pc      = rd_valid ? rd_entry_s[DW +: PC_WIDTH] : '0;
    assign rd_data    = rd_valid ? rd_entry_s[DW-1:0] : '0;
    assign count      = count_r;
    assign state      = state_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: constant vector table, hand-written corner sequences and a randomized
// run checked against a queue-based reference model.
module tb_trace_capture;
    localparam int PW    = 64;
    localparam int DWC   = 64;
    localparam int NCH   = 2;
    localparam int DEPTH = 16;
    localparam int POST  = 4;
    localparam int DW    = NCH*DWC;

    logic            clock    = 1'b0;
    logic            reset_n  = 1'b0;
    logic            cap_en   = 1'b0;
    logic            mode     = 1'b0;
    logic            arm      = 1'b0;
    logic            trig     = 1'b0;
    logic            rd_ready = 1'b0;
    logic [PW-1:0]   pc_in    = '0;
    logic [DW-1:0]   data_in  = '0;
    logic            rd_valid;
    logic [PW-1:0]   rd_pc;
    logic [DW-1:0]   rd_data;
    logic [4:0]      count;
    logic [1:0]      state;
    logic            overflow;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    logic [31:0]     rd_ts;
`endif

    trace_capture #(
        .PC_WIDTH(PW), .DATA_WIDTH(DWC), .NUM_CH(NCH), .DEPTH(DEPTH), .POST_TRIG(POST)
    ) dut (
        .clock(clock), .reset_n(reset_n), .cap_en(cap_en), .pc_in(pc_in), .data_in(data_in),
        .mode(mode), .arm(arm), .trig(trig), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_pc(rd_pc), .rd_data(rd_data),
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
        .rd_ts(rd_ts),
`endif
        .count(count), .state(state), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [PW-1:0] pc;
        logic [DW-1:0] data;
        logic [31:0]   ts;
    } ent_t;

    typedef struct {
        bit a, md, tg, ce, rr;
        logic [PW-1:0] pc;
        int st, cnt;
        bit vld;
        logic [PW-1:0] epc;
    } vec_t;

    ent_t        q[$];
    int          m_state, m_post;
    bit          m_ovf, m_mode;
    logic [31:0] m_ts;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        tbl[17];
    logic [PW-1:0] held_pc;

    task automatic check_eq(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_state = 0; m_post = 0; m_ovf = 1'b0; m_mode = 1'b0; m_ts = 32'd0;
    endtask

    // Reference model: the buffer is a queue holding at most DEPTH newest samples.
    task automatic model(input bit a, input bit md, input bit tg, input bit ce, input bit rr,
                         input logic [PW-1:0] pc, input logic [DW-1:0] d);
        ent_t e;
        e.pc = pc; e.data = d; e.ts = m_ts;
        if (a) begin
            q.delete(); m_ovf = 1'b0; m_mode = md; m_state = 1; m_post = 0;
        end else if (m_state == 1 || m_state == 2) begin
            if (ce) begin
                q.push_back(e);
                if (q.size() > DEPTH) begin
                    void'(q.pop_front());
                    m_ovf = 1'b1;
                end
            end
            if (m_state == 1) begin
                if (!m_mode) begin
                    if (tg || q.size() == DEPTH) m_state = 3;
                end else if (tg) begin
                    if (POST == 0) m_state = 3;
                    else begin m_state = 2; m_post = POST; end
                end
            end else if (ce) begin
                m_post--;
                if (m_post == 0) m_state = 3;
            end
        end else if (m_state == 3) begin
            if (rr && q.size() != 0) void'(q.pop_front());
        end
        m_ts = m_ts + 32'd1;
    endtask

    task automatic step(input bit a, input bit md, input bit tg, input bit ce, input bit rr,
                        input logic [PW-1:0] pc, input logic [DW-1:0] d);
        arm = a; mode = md; trig = tg; cap_en = ce; rd_ready = rr; pc_in = pc; data_in = d;
        model(a, md, tg, ce, rr, pc, d);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW-1:0] dfor(input logic [PW-1:0] pc);
        return {~pc, pc ^ 64'h5A5A_0000_1234_0000};
    endfunction

    task automatic check_all(input string tag);
        bit            v;
        logic [PW-1:0] epc;
        logic [DW-1:0] ed;
        logic [31:0]   ets;
        v = (m_state == 3) && (q.size() != 0);
        epc = '0; ed = '0; ets = 32'd0;
        if (v) begin
            epc = q[0].pc; ed = q[0].data; ets = q[0].ts;
        end
        check_eq({tag, ".state"},    256'(state),    256'(m_state));
        check_eq({tag, ".count"},    256'(count),    256'(q.size()));
        check_eq({tag, ".overflow"}, 256'(overflow), 256'(m_ovf));
        check_eq({tag, ".rd_valid"}, 256'(rd_valid), 256'(v));
        check_eq({tag, ".rd_pc"},    256'(rd_pc),    256'(epc));
        check_eq({tag, ".rd_data"},  256'(rd_data),  256'(ed));
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
        check_eq({tag, ".rd_ts"},    256'(rd_ts),    256'(ets));
`endif
    endtask

    initial begin : main
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   1, 0, 1'b0, 64'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0,   1, 1, 1'b0, 64'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd4,   1, 2, 1'b0, 64'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd8,   3, 3, 1'b1, 64'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0,   3, 2, 1'b1, 64'd4};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0,   3, 1, 1'b1, 64'd8};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0,   3, 0, 1'b0, 64'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0,   3, 0, 1'b0, 64'd0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0,   1, 0, 1'b0, 64'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd100, 2, 1, 1'b0, 64'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0,   2, 1, 1'b0, 64'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd104, 2, 2, 1'b0, 64'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd108, 2, 3, 1'b0, 64'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd112, 2, 4, 1'b0, 64'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd116, 3, 5, 1'b1, 64'd100};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0,   1, 0, 1'b0, 64'd0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd200, 1, 1, 1'b0, 64'd0};

        // Power-on reset values, observed between clock edges.
        m_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;

        // Constant vector table: early trigger, arm+trig same cycle, post-trigger count, re-arm.
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].a, tbl[i].md, tbl[i].tg, tbl[i].ce, tbl[i].rr, tbl[i].pc, dfor(tbl[i].pc));
            check_eq($sformatf("tbl%0d.state", i), 256'(state),    256'(tbl[i].st));
            check_eq($sformatf("tbl%0d.count", i), 256'(count),    256'(tbl[i].cnt));
            check_eq($sformatf("tbl%0d.valid", i), 256'(rd_valid), 256'(tbl[i].vld));
            check_eq($sformatf("tbl%0d.rd_pc", i), 256'(rd_pc),    256'(tbl[i].epc));
        end

        // Stop-when-full fill, then drain with a 1,0,1 rd_ready pattern.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, '0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'(4*i), dfor(64'(4*i)));
            if (i == 14) check_eq("fill.not_done", 256'(state), 256'(1));
        end
        check_eq("fill.state", 256'(state), 256'(3));
        check_eq("fill.count", 256'(count), 256'(16));
        check_eq("fill.ovf",   256'(overflow), 256'(0));
        check_eq("fill.first", 256'(rd_pc), 256'(0));
        check_all("fill");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, '0);
        held_pc = rd_pc;
        check_eq("bp.pop1", 256'(count), 256'(15));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, '0);
        check_eq("bp.hold_pc", 256'(rd_pc), 256'(held_pc));
        check_eq("bp.hold_cnt", 256'(count), 256'(15));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, '0);
        check_eq("bp.pop2", 256'(count), 256'(14));
        for (int k = 2; k < 16; k++) begin
            check_eq($sformatf("drain0.pc%0d", k), 256'(rd_pc), 256'(4*k));
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, '0);
        end
        check_eq("drain0.empty", 256'(rd_valid), 256'(0));
        check_all("drain0");

        // Ring wrap with post-trigger window.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, '0);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, (i == 25), 1'b1, 1'b0, 64'(4*i), dfor(64'(4*i)));
            if (i == 28) check_eq("ring.post", 256'(state), 256'(2));
        end
        check_eq("ring.state", 256'(state), 256'(3));
        check_eq("ring.ovf",   256'(overflow), 256'(1));
        check_eq("ring.count", 256'(count), 256'(16));
        for (int k = 0; k < 16; k++) begin
            check_eq($sformatf("drain1.pc%0d", k), 256'(rd_pc), 256'(56 + 4*k));
            check_all("drain1");
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, '0);
        end
        check_eq("drain1.count", 256'(count), 256'(0));

        // Asynchronous reset mid-capture takes effect without a clock edge.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'(i), dfor(64'(i)));
        check_eq("prereset.count", 256'(count), 256'(5));
        reset_n = 1'b0;
        #1;
        check_eq("areset.state", 256'(state), 256'(0));
        check_eq("areset.count", 256'(count), 256'(0));
        check_eq("areset.valid", 256'(rd_valid), 256'(0));
        m_reset();
        reset_n = 1'b1;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), {$urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom});
            check_all("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
# trace_capture

Parametrised trace buffer for the single-cycle datapath. Each cycle it samples the datapath's PC plus NUM_CH register-read values (rd1, rd2, ...) into an on-chip ring, under an arm/trigger state machine. After capture it drains entries oldest-first over a valid/ready port. It replaces per-cycle console printing in benches and gives a synthesizable debug tap on the datapath.

## Interface
- PC_WIDTH, 64, width of captured PC
- DATA_WIDTH, 64, width of each data channel
- NUM_CH, 2, number of data channels (1..8)
- DEPTH, 16, entries in buffer (power of two, >=2)
- POST_TRIG, 4, samples captured after trigger in ring mode (0..DEPTH-1)
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cap_en  in  1  sample valid this cycle
- pc_in  in  PC_WIDTH  PC to capture
- data_in  in  NUM_CH*DATA_WIDTH  channel k at [k*DATA_WIDTH +: DATA_WIDTH]
- mode  in  1  0 = stop-when-full, 1 = ring with post-trigger; sampled only on arm
- arm  in  1  single-cycle pulse: clear buffer, start capture
- trig  in  1  trigger event
- rd_valid  out  1  oldest entry available (DONE only)
- rd_ready  in  1  consumer accepts entry
- rd_pc  out  PC_WIDTH  PC of oldest entry
- rd_data  out  NUM_CH*DATA_WIDTH  data of oldest entry
- count  out  $clog2(DEPTH+1)  entries held
- state  out  2  FSM state
- overflow  out  1  sticky: ring overwrote at least one entry

## Operation
- States: IDLE=0, ARMED=1, POST=2, DONE=3.
- IDLE: no writes. arm -> ARMED; same edge: wr_ptr=rd_ptr=0, count=0, overflow=0, latch mode.
- ARMED: cap_en=1 writes {pc_in,data_in} at wr_ptr, wr_ptr++ (mod DEPTH).
  - mode 0: write that makes count==DEPTH -> DONE. trig -> DONE (the same-cycle sample is still written if cap_en=1).
  - mode 1: write when count==DEPTH overwrites oldest, rd_ptr++, count holds, overflow<=1. trig -> POST with post counter = POST_TRIG; if POST_TRIG==0 -> DONE directly. Same-cycle sample is written.
- POST: writes as in ARMED mode 1; each write decrements post counter; the write taking it to 0 -> DONE. trig ignored.
- DONE: no writes. rd_valid = (count!=0). rd_valid&&rd_ready: rd_ptr++, count--. Stays DONE when empty.
- arm in any state (including ARMED, POST, DONE) restarts as from IDLE; unread entries discarded.
- arm and trig same cycle: arm wins, trig ignored.
- rd_valid=0 outside DONE; rd_ready ignored there.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, count=0, overflow=0, rd_valid=0, rd_pc=0, rd_data=0, pointers and post counter 0. Buffer contents undefined and never visible.
- Write latency: sample on edge N is visible in count after edge N; readable at rd_pc/rd_data first cycle in DONE.
- rd_pc/rd_data are show-ahead: combinational from the entry at rd_ptr, stable while rd_valid&&!rd_ready.
- One pop per cycle max; DONE-only reads mean no write/read collision.
- Pointers wrap DEPTH-1 -> 0; count saturates at DEPTH.
- reset_n asserted mid-capture or mid-drain aborts immediately; deassertion resumes in IDLE.

## Configuration
- TRACE_CAPTURE_TIMESTAMP_EN defined: 32-bit free-running cycle counter (0 at reset, +1 every clock, wraps 2^32-1 -> 0) stored with each entry; extra port rd_ts  out  32, reset 0, show-ahead like rd_pc.
- Undefined: no counter, no rd_ts port, entry width PC_WIDTH+NUM_CH*DATA_WIDTH.

## Test plan
- Reset: reset_n=0 mid-ARMED with count=5 -> state=0, count=0, rd_valid=0 immediately, no clock needed.
- Mode 0 fill: arm, cap_en=1 with pc_in=0,4,8... for 16 cycles -> DONE after 16th write, count=16, drain yields pc 0..60 in order, overflow=0.
- Mode 1 wrap + post: DEPTH=16, POST_TRIG=4, pc_in=4*i for i=0..29, trig at i=25 -> DONE after i=29, overflow=1, drain yields pc 56..116 (i=14..29).
- Early trigger mode 0: trig with cap_en=1 on 3rd sample -> DONE, count=3, drain pc 0,4,8.
- Backpressure: in DONE toggle rd_ready 1,0,1 -> rd_pc holds while rd_ready=0, exactly two pops, count 16->14.
- Arm+trig same cycle from IDLE in mode 1 -> state=ARMED, not POST; TRACE_CAPTURE_TIMESTAMP_EN build: consecutive entries' rd_ts differ by 1.
